// File: rtl/digct_pkg.sv
// Shared types for the DigCt receive path: measurement FSM states and read-select codes.
package digct_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_B0  = 2'd0,
        SEL_B1  = 2'd1,
        SEL_B2  = 2'd2,
        SEL_OVF = 2'd3
    } rd_sel_e;

    localparam int NBITS = 3;

endpackage

// File: rtl/digct_filt.sv
// One DigCt bit: 2-flop synchroniser, FILT-cycle persistence filter, rising-edge detector.
module digct_filt #(
    parameter int FILT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_async,
    output logic rise
);

    localparam int CW = $clog2(FILT + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          filt_q, filt_d;
    logic          filt_dly_q, filt_dly_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d    = in_async;
        sync2_d    = sync1_q;
        filt_d     = filt_q;
        filt_dly_d = filt_q;
        cnt_d      = '0;
        // The flip happens on the cycle the counter would reach FILT.
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILT - 1)) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rise = filt_q & ~filt_dly_q;

endmodule

// File: rtl/digct_sink.sv
// DigCt receive end: per-bit edge counting over a programmable window, with a
// one-cycle request/acknowledge read port for the host.
module digct_sink
    import digct_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int FILT  = 2,
    parameter int WIN_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [2:0]       IN_SIG,
    input  logic             START,
    input  logic [WIN_W-1:0] WIN_LEN,
    input  logic             RD_REQ,
    input  logic [1:0]       RD_SEL,
    output logic             RD_ACK,
    output logic [CNT_W-1:0] RD_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic [2:0]       OVF
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NBITS-1:0]            rise;
    state_e                      state_q, state_d;
    logic [WIN_W-1:0]            win_q, win_d;
    logic [NBITS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0]            ovf_q, ovf_d;
    logic                        rd_ack_q, rd_ack_d;
    logic [CNT_W-1:0]            rd_data_q, rd_data_d;

    for (genvar g = 0; g < NBITS; g++) begin : g_filt
        digct_filt #(.FILT(FILT)) u_filt (
            .clk      (CLK),
            .rst_n    (RST_N),
            .in_async (IN_SIG[g]),
            .rise     (rise[g])
        );
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    cnt_d = '0;
                    ovf_d = '0;
                    if (WIN_LEN == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        win_d   = WIN_LEN;
                    end
                end
            end
            ST_RUN: begin
                win_d = win_q - 1'b1;
                if (win_q == WIN_W'(1)) begin
                    state_d = ST_DONE;
                end
                for (int i = 0; i < NBITS; i++) begin
                    if (rise[i]) begin
                        if (cnt_q[i] == CNT_MAX) begin
                            ovf_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data captures pre-update values so a read never sees its own cycle's increment.
    always_comb begin
        rd_ack_d  = RD_REQ;
        rd_data_d = rd_data_q;
        if (RD_REQ) begin
            case (rd_sel_e'(RD_SEL))
                SEL_B0:  rd_data_d = cnt_q[0];
                SEL_B1:  rd_data_d = cnt_q[1];
                SEL_B2:  rd_data_d = cnt_q[2];
                SEL_OVF: rd_data_d = {{(CNT_W-NBITS){1'b0}}, ovf_q};
                default: rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= '0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign BUSY    = (state_q == ST_RUN);
    assign DONE    = (state_q == ST_DONE);
    assign OVF     = ovf_q;
    assign RD_ACK  = rd_ack_q;
    assign RD_DATA = rd_data_q;

endmodule

// File: tb/tb_digct_sink.sv
// Directed bench for digct_sink: filter latency, window length, counting, saturation, reset.
module tb_digct_sink;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [2:0]  IN_SIG;
    logic        START;
    logic [15:0] WIN_LEN;
    logic        RD_REQ;
    logic [1:0]  RD_SEL;
    logic        RD_ACK;
    logic [7:0]  RD_DATA;
    logic        BUSY;
    logic        DONE;
    logic [2:0]  OVF;

    int tests = 0;
    int fails = 0;
    int busy_n;

    always #5 CLK = ~CLK;

    digct_sink #(.CNT_W(8), .FILT(2), .WIN_W(16)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .IN_SIG  (IN_SIG),
        .START   (START),
        .WIN_LEN (WIN_LEN),
        .RD_REQ  (RD_REQ),
        .RD_SEL  (RD_SEL),
        .RD_ACK  (RD_ACK),
        .RD_DATA (RD_DATA),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .OVF     (OVF)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_read(input logic [1:0] sel, input logic [31:0] exp, input string tag);
        RD_REQ = 1'b1;
        RD_SEL = sel;
        tick(1);
        RD_REQ = 1'b0;
        check({tag, "_ack"}, {31'd0, RD_ACK}, 32'd1);
        check(tag, {24'd0, RD_DATA}, exp);
    endtask

    // Returns at the negedge just after the edge that accepts START.
    task automatic start_win(input logic [15:0] w);
        WIN_LEN = w;
        START   = 1'b1;
        tick(1);
        START   = 1'b0;
    endtask

    initial begin
        RST_N   = 1'b0;
        IN_SIG  = 3'b000;
        START   = 1'b0;
        WIN_LEN = '0;
        RD_REQ  = 1'b0;
        RD_SEL  = 2'd0;
        tick(3);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_ovf", {29'd0, OVF}, 32'd0);
        check("rst_ack", {31'd0, RD_ACK}, 32'd0);
        check("rst_data", {24'd0, RD_DATA}, 32'd0);
        RST_N = 1'b1;
        tick(2);
        do_read(2'd0, 32'd0, "idle_rd0");
        tick(1);
        check("idle_ack_drop", {31'd0, RD_ACK}, 32'd0);

        // single-cycle glitch is filtered out
        start_win(16'd20);
        IN_SIG[0] = 1'b1;
        tick(1);
        IN_SIG[0] = 1'b0;
        tick(25);
        check("glitch_done", {31'd0, DONE}, 32'd1);
        do_read(2'd0, 32'd0, "glitch_cnt");

        // 3-cycle pulse: edge lands 5 edges after the rise, beyond a 4-cycle window
        start_win(16'd4);
        IN_SIG[0] = 1'b1;
        tick(3);
        IN_SIG[0] = 1'b0;
        tick(6);
        check("lat4_done", {31'd0, DONE}, 32'd1);
        do_read(2'd0, 32'd0, "lat4_cnt");

        // same pulse with a 5-cycle window: edge falls in the last RUN cycle
        start_win(16'd5);
        IN_SIG[0] = 1'b1;
        tick(3);
        IN_SIG[0] = 1'b0;
        tick(6);
        do_read(2'd0, 32'd1, "lat5_cnt");

        // 20-cycle window, 4 pulses on bit 1
        start_win(16'd20);
        busy_n = 0;
        for (int k = 0; k < 24; k++) begin
            IN_SIG[1] = (k < 16) && ((k % 4) < 2);
            if (BUSY) busy_n++;
            tick(1);
        end
        check("win20_busy_cycles", busy_n, 32'd20);
        check("win20_done", {31'd0, DONE}, 32'd1);
        RD_REQ = 1'b1;
        RD_SEL = 2'd1;
        tick(1);
        check("b2b_ack1", {31'd0, RD_ACK}, 32'd1);
        check("b2b_cnt1", {24'd0, RD_DATA}, 32'd4);
        RD_SEL = 2'd2;
        tick(1);
        check("b2b_ack2", {31'd0, RD_ACK}, 32'd1);
        check("b2b_cnt2", {24'd0, RD_DATA}, 32'd0);
        RD_REQ = 1'b0;
        tick(1);
        check("b2b_ack_low", {31'd0, RD_ACK}, 32'd0);
        check("b2b_data_hold", {24'd0, RD_DATA}, 32'd0);
        do_read(2'd0, 32'd0, "win20_cnt0");

        // 300 edges on bit 2: saturation and overflow
        start_win(16'd2000);
        for (int k = 0; k < 300; k++) begin
            IN_SIG[2] = 1'b1;
            tick(2);
            IN_SIG[2] = 1'b0;
            tick(2);
        end
        for (int k = 0; k < 1000 && !DONE; k++) tick(1);
        check("sat_done", {31'd0, DONE}, 32'd1);
        do_read(2'd2, 32'd255, "sat_cnt2");
        do_read(2'd3, 32'd4, "sat_ovf_rd");
        do_read(2'd1, 32'd0, "sat_cnt1_cleared");
        check("sat_ovf_port", {29'd0, OVF}, 32'd4);

        // zero-length window goes straight to DONE
        start_win(16'd0);
        check("zero_done", {31'd0, DONE}, 32'd1);
        busy_n = 0;
        for (int k = 0; k < 24; k++) begin
            IN_SIG[0] = (k < 16) && ((k % 4) < 2);
            if (BUSY) busy_n++;
            tick(1);
        end
        check("zero_busy_cycles", busy_n, 32'd0);
        do_read(2'd0, 32'd0, "zero_cnt0");
        do_read(2'd3, 32'd0, "zero_ovf_rd");
        check("zero_ovf_port", {29'd0, OVF}, 32'd0);

        // reset in the middle of a window with count 7
        start_win(16'd100);
        for (int k = 0; k < 7; k++) begin
            IN_SIG[0] = 1'b1;
            tick(2);
            IN_SIG[0] = 1'b0;
            tick(2);
        end
        tick(6);
        check("mid_busy", {31'd0, BUSY}, 32'd1);
        do_read(2'd0, 32'd7, "mid_cnt0");
        RST_N  = 1'b0;
        RD_REQ = 1'b1;
        RD_SEL = 2'd0;
        tick(1);
        check("mrst_ack", {31'd0, RD_ACK}, 32'd0);
        check("mrst_busy", {31'd0, BUSY}, 32'd0);
        check("mrst_done", {31'd0, DONE}, 32'd0);
        check("mrst_ovf", {29'd0, OVF}, 32'd0);
        check("mrst_data", {24'd0, RD_DATA}, 32'd0);
        RST_N  = 1'b1;
        RD_REQ = 1'b0;
        tick(2);
        check("post_busy", {31'd0, BUSY}, 32'd0);
        check("post_done", {31'd0, DONE}, 32'd0);
        do_read(2'd0, 32'd0, "post_cnt0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
